// File: rtl/branch_resolve_unit_if.sv
// Handshake bundle for branch_resolve_unit: the request side, the result side and flush.
// The br_count/mis_count members exist only when BRANCH_PERF_CNT_EN is defined.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic            is_rvc;
  logic            out_valid;
  logic            out_ready;
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            misalign;
  logic            illegal;
`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mis_count;
`endif

  modport master (
    output flush, in_valid, funct3, rs1, rs2, pc, imm, pred_taken, is_rvc, out_ready,
    input  in_ready, out_valid, taken, mispredict, redirect_pc, misalign, illegal
`ifdef BRANCH_PERF_CNT_EN
    , input br_count, mis_count
`endif
  );

  modport slave (
    input  flush, in_valid, funct3, rs1, rs2, pc, imm, pred_taken, is_rvc, out_ready,
    output in_ready, out_valid, taken, mispredict, redirect_pc, misalign, illegal
`ifdef BRANCH_PERF_CNT_EN
    , output br_count, mis_count
`endif
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves RV conditional branches, checks the front-end prediction and registers the redirect.
// Optional saturating performance counters are built when BRANCH_PERF_CNT_EN is defined.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int C_EXT = 0,
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_resolve_unit_if.slave br
);
  logic            eq, lt_s, lt_u, res_taken, res_illegal, tgt_odd;
  logic [XLEN-1:0] target, fall_thru;
  logic            capture;

  logic            valid_q, valid_d;
  logic            taken_q, taken_d;
  logic            mis_q, mis_d;
  logic            misal_q, misal_d;
  logic            ill_q, ill_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    eq          = (br.rs1 == br.rs2);
    lt_s        = ($signed(br.rs1) < $signed(br.rs2));
    lt_u        = (br.rs1 < br.rs2);
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    case (br.funct3)
      3'b000:  res_taken = eq;
      3'b001:  res_taken = !eq;
      3'b100:  res_taken = lt_s;
      3'b101:  res_taken = !lt_s;
      3'b110:  res_taken = lt_u;
      3'b111:  res_taken = !lt_u;
      default: res_illegal = 1'b1;
    endcase
    target    = br.pc + br.imm;
    fall_thru = br.pc + (((C_EXT != 0) && br.is_rvc) ? XLEN'(2) : XLEN'(4));
    // With compressed support only bit 0 matters; otherwise targets must be word aligned.
    tgt_odd   = (C_EXT != 0) ? target[0] : target[1];
  end

  assign br.in_ready = !valid_q || br.out_ready;
  assign capture     = br.in_valid && br.in_ready;

  always_comb begin
    valid_d = valid_q;
    taken_d = taken_q;
    mis_d   = mis_q;
    misal_d = misal_q;
    ill_d   = ill_q;
    pc_d    = pc_q;
    if (br.flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      taken_d = res_taken;
      mis_d   = !res_illegal && (res_taken != br.pred_taken);
      misal_d = res_taken && tgt_odd;
      ill_d   = res_illegal;
      pc_d    = res_taken ? target : fall_thru;
    end else if (br.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      mis_q   <= 1'b0;
      misal_q <= 1'b0;
      ill_q   <= 1'b0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      taken_q <= taken_d;
      mis_q   <= mis_d;
      misal_q <= misal_d;
      ill_q   <= ill_d;
      pc_q    <= pc_d;
    end
  end

  assign br.out_valid   = valid_q;
  assign br.taken       = taken_q;
  assign br.mispredict  = mis_q;
  assign br.misalign    = misal_q;
  assign br.illegal     = ill_q;
  assign br.redirect_pc = pc_q;

`ifdef BRANCH_PERF_CNT_EN
  logic             cnt_evt;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  // A result killed by flush in the same cycle it is handed over is not counted.
  assign cnt_evt = valid_q && br.out_ready && !ill_q && !br.flush;

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (cnt_evt) begin
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
      if (mis_q && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br.br_count  = br_cnt_q;
  assign br.mis_count = mis_cnt_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases plus randomized traffic
// compared against a cycle-level reference model built from the branch rules.
module tb_branch_resolve_unit;
  localparam int XLEN = 32;
  localparam int CE   = 0;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic        taken;
    logic        mis;
    logic        misal;
    logic        ill;
    logic [31:0] rpc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;

  logic m_valid;
  res_t m_res;
  int   m_br, m_mc;

  branch_resolve_unit_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

  branch_resolve_unit #(.XLEN(XLEN), .C_EXT(CE), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .br   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic longint as_signed(input logic [31:0] v);
    longint s = longint'(v);
    if (v >= 32'h8000_0000) s = s - 64'h1_0000_0000;
    return s;
  endfunction

  function automatic res_t resolve(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pcv, input logic [31:0] immv,
                                   input logic pt, input logic rvc);
    res_t   r;
    longint tgt, ft;
    bit     tk = 0;
    case (f)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd4: tk = as_signed(a) < as_signed(b);
      3'd5: tk = !(as_signed(a) < as_signed(b));
      3'd6: tk = longint'(a) < longint'(b);
      3'd7: tk = !(longint'(a) < longint'(b));
      default: tk = 0;
    endcase
    tgt     = (longint'(pcv) + longint'(immv)) % 64'h1_0000_0000;
    ft      = (longint'(pcv) + ((CE != 0 && rvc) ? 2 : 4)) % 64'h1_0000_0000;
    r.ill   = (f == 3'd2) || (f == 3'd3);
    r.taken = tk;
    r.mis   = !r.ill && (tk != pt);
    r.misal = tk && (((CE != 0) ? tgt : tgt / 2) % 2 == 1);
    r.rpc   = tk ? 32'(tgt) : 32'(ft);
    return r;
  endfunction

  task automatic check_outputs();
    chk("out_valid", bus.out_valid, m_valid);
    chk("taken", bus.taken, m_res.taken);
    chk("mispredict", bus.mispredict, m_res.mis);
    chk("misalign", bus.misalign, m_res.misal);
    chk("illegal", bus.illegal, m_res.ill);
    chk("redirect_pc", bus.redirect_pc, m_res.rpc);
`ifdef BRANCH_PERF_CNT_EN
    chk("br_count", bus.br_count, m_br);
    chk("mis_count", bus.mis_count, m_mc);
`endif
  endtask

  // Inputs are already applied; advance the model and the DUT by one clock.
  task automatic tick();
    logic rdy;
    #1;
    rdy = !m_valid || bus.out_ready;
    chk("in_ready", bus.in_ready, rdy);
    if (!rst_n) begin
      m_valid = 0;
      m_res   = '0;
      m_br    = 0;
      m_mc    = 0;
    end else if (bus.flush) begin
      m_valid = 0;
    end else begin
      if (m_valid && bus.out_ready && !m_res.ill) begin
        if (m_br < CMAX) m_br++;
        if (m_res.mis && m_mc < CMAX) m_mc++;
      end
      if (bus.in_valid && rdy) begin
        m_valid = 1;
        m_res   = resolve(bus.funct3, bus.rs1, bus.rs2, bus.pc, bus.imm, bus.pred_taken, bus.is_rvc);
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pcv, input logic [31:0] immv, input logic pt);
    bus.in_valid   = 1;
    bus.funct3     = f;
    bus.rs1        = a;
    bus.rs2        = b;
    bus.pc         = pcv;
    bus.imm        = immv;
    bus.pred_taken = pt;
    bus.is_rvc     = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    logic [31:0] held_pc;
    rst_n         = 0;
    bus.flush     = 0;
    bus.out_ready = 1;
    req(3'd0, 0, 0, 0, 0, 0);
    bus.in_valid  = 0;
    @(negedge clk);
    do_reset();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_redirect_pc", bus.redirect_pc, 0);

    // signed vs unsigned ordering of 0xFFFFFFFF against 1
    req(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 0);
    tick();
    chk("blt_neg", bus.taken, 1);
    req(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 0);
    tick();
    chk("bltu_big", bus.taken, 0);
    req(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 0);
    tick();
    chk("bgeu_big", bus.taken, 1);

    req(3'b000, 5, 5, 32'h1000, 32'hFFFF_FFF0, 0);
    tick();
    chk("beq_mis", bus.mispredict, 1);
    chk("beq_target", bus.redirect_pc, 32'h0000_0FF0);
    req(3'b000, 5, 6, 32'h1000, 32'hFFFF_FFF0, 0);
    tick();
    chk("beq_fall", bus.redirect_pc, 32'h0000_1004);
    chk("beq_nomis", bus.mispredict, 0);

    // backpressure: held result stays put, in_ready low
    held_pc = bus.redirect_pc;
    bus.out_ready = 0;
    req(3'b001, 1, 2, 32'h3000, 32'h20, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_stable", bus.redirect_pc, held_pc);
    end
    bus.out_ready = 1;
    tick();
    chk("bp_replace_valid", bus.out_valid, 1);
    chk("bp_replace_pc", bus.redirect_pc, 32'h3020);

    // flush right after a capture
    req(3'b000, 7, 7, 32'h4000, 32'h8, 0);
    tick();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    bus.in_valid = 0;
    chk("flush_drop", bus.out_valid, 0);
    tick();

    req(3'b000, 7, 7, 32'h4000, 32'h8, 0);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_taken", bus.taken, 0);

    req(3'b010, 3, 3, 32'h5000, 32'h10, 1);
    tick();
    chk("ill_flag", bus.illegal, 1);
    chk("ill_taken", bus.taken, 0);
    chk("ill_mis", bus.mispredict, 0);
    req(3'b000, 9, 9, 32'h2000, 32'h6, 1);
    tick();
    chk("misal_flag", bus.misalign, 1);
    chk("misal_pc", bus.redirect_pc, 32'h2006);
    bus.in_valid = 0;
    tick();

`ifdef BRANCH_PERF_CNT_EN
    do_reset();
    chk("cnt_rst_br", bus.br_count, 0);
    for (int i = 0; i < 20; i++) begin
      req(3'b000, i, i, 32'h100 + 32'(i * 4), 32'h40, 0);
      tick();
    end
    bus.in_valid = 0;
    tick();
    chk("cnt_sat_br", bus.br_count, CMAX);
    chk("cnt_sat_mis", bus.mis_count, CMAX);
    req(3'b011, 1, 1, 32'h100, 32'h40, 0);
    tick();
    bus.in_valid = 0;
    tick();
    chk("cnt_ill_br", bus.br_count, CMAX);
    do_reset();
    chk("cnt_rst_mis", bus.mis_count, 0);
`endif

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = $urandom;
      req(3'($urandom_range(0, 7)), a, ($urandom_range(0, 3) == 0) ? a : $urandom,
          $urandom, $urandom, 1'($urandom_range(0, 1)));
      bus.is_rvc    = 1'($urandom_range(0, 1));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      rst_n         = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1;
    bus.flush = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised, pipelined successor to the single-cycle branch comparator. It resolves every RV conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU) from funct3 and computes the target. It checks the result against the front-end prediction and emits a registered redirect/mispredict result. It sits between the execute-stage operand mux and the fetch redirect logic, with valid/ready handshakes on both sides.

Parameters:
XLEN, 32, operand, PC and immediate width in bits
C_EXT, 0, 1 = compressed ISA supported: 2-byte target alignment legal, fall-through size taken from is_rvc
CNT_W, 32, width of the optional performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous pipeline kill; drops any held result
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request this cycle
funct3  in  3  branch condition encoding
rs1  in  XLEN  operand 1
rs2  in  XLEN  operand 2
pc  in  XLEN  branch instruction address
imm  in  XLEN  sign-extended B-immediate
pred_taken  in  1  front-end predicted direction
is_rvc  in  1  instruction is 16-bit (ignored when C_EXT=0)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
taken  out  1  resolved direction
mispredict  out  1  taken != pred_taken (0 when illegal)
redirect_pc  out  XLEN  taken ? target : fall-through
misalign  out  1  taken and target misaligned
illegal  out  1  funct3 is 010 or 011

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0; taken, mispredict, misalign and illegal = 0; redirect_pc = 0; counters = 0. Reset mid-transfer drops the held result. in_ready is 1 in the first cycle after reset.
- Single output register stage; latency 1 cycle from input handshake to out_valid.
- in_ready = !out_valid || out_ready (combinational). Full throughput: back-to-back results with out_ready held at 1.
- Capture occurs when in_valid && in_ready. If out_valid && !out_ready, the held result and all outputs stay stable; no capture.
- A result is consumed when out_valid && out_ready. If there is no new capture in the same cycle, out_valid falls to 0.
- Comparison width is XLEN:
  - eq = rs1==rs2
  - lt_s = signed compare
  - lt_u = unsigned compare
- funct3 decode:
  - 000 taken=eq; 001 taken=!eq
  - 100 taken=lt_s; 101 taken=!lt_s
  - 110 taken=lt_u; 111 taken=!lt_u
  - 010, 011: taken=0, illegal=1, mispredict=0, misalign=0, redirect_pc=fall-through
  - all others: illegal=0
- target = (pc + imm) mod 2^XLEN, wrap-around silently.
- Fall-through = pc + 4, or pc + 2 when C_EXT=1 && is_rvc; mod 2^XLEN.
- Misalignment:
  - C_EXT=0: misalign = taken && target[1]
  - C_EXT=1: misalign = taken && target[0]
  - redirect_pc still reports the target when misalign=1.
- flush: synchronous, highest priority after reset. The next state is out_valid=0 and any same-cycle capture is discarded. in_ready is still computed normally during the flush cycle.
- Simultaneous consume + capture: the new result replaces the old one with out_valid remaining 1.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- When defined, add outputs br_count [CNT_W] and mis_count [CNT_W].
- On each output handshake of a non-illegal result:
  - br_count increments.
  - mis_count increments if mispredict=1.
  - Both counters saturate at all-ones; no wrap.
- Flushed results are not counted; counters clear only on reset.
- When undefined: ports and counter logic are absent; all other behaviour is unchanged.

Test Plan:
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=0x00000001, funct3=100 -> taken=1 next cycle; funct3=110 -> taken=0; funct3=111 -> taken=1.
- Redirect/mispredict: pc=0x1000, imm=0xFFFFFFF0, funct3=000, rs1=rs2=5, pred_taken=0 -> taken=1, mispredict=1, redirect_pc=0x0FF0; same with rs2=6 -> redirect_pc=0x1004, mispredict=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> consume and capture in the same cycle, out_valid stays 1.
- Flush and reset: capture, then flush=1 in the next cycle -> out_valid=0, held result lost. Repeat with rst_n=0 instead -> all outputs 0 and, with BRANCH_PERF_CNT_EN, counters 0.
- Illegal and misalign: funct3=010 -> illegal=1, taken=0, mispredict=0 even with pred_taken=1. C_EXT=0, pc=0x2000, imm=0x6, taken -> misalign=1, redirect_pc=0x2006.
- Counters (BRANCH_PERF_CNT_EN, CNT_W=4): 20 consumed mispredicted branches -> br_count=mis_count=0xF (saturated); one illegal result -> no change.
